// File: rtl/afe_mux_sequencer_pkg.sv
// Shared types and defaults for the AFE mux sequencer.
// Holds the FSM state encoding and the channel search.
package afe_seq_pkg;

  localparam int NUM_CH      = 4;
  localparam int FAULT_LIMIT = 3;
  localparam int BIAS_WAIT   = 16;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    SETTLE,
    SAMPLE,
    FAULT
  } state_t;

  // Next enabled channel above cur, wrapping 3->0; cur itself last.
  function automatic logic [1:0] next_ch(
    input logic [3:0] mask,
    input logic [1:0] cur
  );
    logic [1:0] c;
    next_ch = cur;
    for (int i = NUM_CH; i >= 1; i--) begin
      c = cur + 2'(i);
      if (mask[c]) next_ch = c;
    end
  endfunction

endpackage

// File: rtl/afe_mux_sequencer_sync2.sv
// Two-flop synchronizer for the asynchronous comparator output.
// Resets to 0 so no spurious over-threshold sample follows reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the async input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/afe_mux_sequencer.sv
// AFE sequencer: bias warm-up, mux stepping, comparator
// sampling and persistent-fault latching.
module afe_mux_sequencer #(
  parameter int NUM_CH      = afe_seq_pkg::NUM_CH,
  parameter int SETTLE_W    = 8,
  parameter int BIAS_WAIT   = afe_seq_pkg::BIAS_WAIT,
  parameter int FAULT_LIMIT = afe_seq_pkg::FAULT_LIMIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                comp_in,
  input  logic                clr_fault,
  output logic [1:0]          mux_sel,
  output logic                bias_en,
  output logic                samp_strobe,
  output logic                latch_set,
  output logic                fault,
  output logic [1:0]          fault_ch,
  output logic [NUM_CH-1:0]   result,
  output logic                busy
);

  import afe_seq_pkg::*;

  localparam int BW = $clog2(BIAS_WAIT + 1);
  localparam int CW = $clog2(FAULT_LIMIT + 1);

  state_t              state;
  logic                comp_s;
  logic [BW-1:0]       bias_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SETTLE_W-1:0] settle_len;
  logic [SETTLE_W-1:0] settle_eff;
  logic [CW-1:0]       cnt [NUM_CH];
  logic [CW-1:0]       cur_cnt;
  logic [CW-1:0]       inc_cnt;
  logic [1:0]          nxt;
  logic                hit;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (comp_in),
    .q   (comp_s)
  );

  assign settle_eff = (settle_cycles == '0) ? SETTLE_W'(1)
                                            : settle_cycles;
  assign cur_cnt = cnt[mux_sel];
  assign inc_cnt = (cur_cnt == CW'(FAULT_LIMIT)) ? cur_cnt
                                                 : cur_cnt + 1'b1;
  assign hit  = comp_s && (inc_cnt == CW'(FAULT_LIMIT));
  assign nxt  = next_ch(ch_mask, mux_sel);
  assign busy = (state != IDLE);

  // Sequencer FSM with registered outputs and per-channel streaks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mux_sel     <= '0;
      bias_en     <= 1'b0;
      samp_strobe <= 1'b0;
      latch_set   <= 1'b0;
      fault       <= 1'b0;
      fault_ch    <= '0;
      result      <= '0;
      bias_cnt    <= '0;
      settle_cnt  <= '0;
      settle_len  <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      samp_strobe <= 1'b0;
      latch_set   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && (|ch_mask)) begin
            state    <= BIAS;
            bias_en  <= 1'b1;
            bias_cnt <= '0;
          end
        end
        BIAS: begin
          if (!en) begin
            state   <= IDLE;
            bias_en <= 1'b0;
          end else if (bias_cnt == BW'(BIAS_WAIT - 1)) begin
            if (|ch_mask) begin
              state      <= SETTLE;
              mux_sel    <= next_ch(ch_mask, 2'd3);
              settle_len <= settle_eff;
              settle_cnt <= '0;
            end else begin
              state   <= IDLE;
              bias_en <= 1'b0;
            end
          end else begin
            bias_cnt <= bias_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (!en) begin
            state   <= IDLE;
            bias_en <= 1'b0;
          end else if (settle_cnt == settle_len - 1'b1) begin
            state       <= SAMPLE;
            samp_strobe <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (!en) begin
            state   <= IDLE;
            bias_en <= 1'b0;
          end else begin
            result[mux_sel] <= comp_s;
            cnt[mux_sel]    <= comp_s ? inc_cnt : '0;
            if (hit) begin
              state     <= FAULT;
              latch_set <= 1'b1;
              fault     <= 1'b1;
              fault_ch  <= mux_sel;
            end else if (|ch_mask) begin
              state      <= SETTLE;
              mux_sel    <= nxt;
              settle_len <= settle_eff;
              settle_cnt <= '0;
            end else begin
              state   <= IDLE;
              bias_en <= 1'b0;
            end
          end
        end
        FAULT: begin
          if (clr_fault) begin
            fault    <= 1'b0;
            fault_ch <= '0;
            if (en) begin
              state    <= BIAS;
              bias_cnt <= '0;
            end else begin
              state   <= IDLE;
              bias_en <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (clr_fault) begin
        for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      end
    end
  end

endmodule
